// File: rtl/fp_sched_pkg.sv
// Shared constants and state encoding for the fp adder scheduler.
package fp_sched_pkg;

  // Width of one IEEE-754 single-precision operand or result.
  localparam int FP32_W = 32;

  // Default limit, in cycles, for each adder wait state before an error response.
  localparam int TIMEOUT_DEFAULT = 31;

  // state      | meaning
  // -----------+---------------------------------------------------------
  // IDLE       | arbitration open, one grant per cycle
  // ISSUE      | operands held, waiting for adder ready to pulse start
  // WAIT_BUSY  | start sent, waiting for adder to drop ready
  // WAIT_DONE  | adder working, waiting for ready to return with result
  // RESP       | one-cycle tagged response on the shared bus
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ISSUE     = 5'b00010,
    ST_WAIT_BUSY = 5'b00100,
    ST_WAIT_DONE = 5'b01000,
    ST_RESP      = 5'b10000
  } sched_state_e;

endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i+1 with
// wrap-around and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             found_o
);

  logic [ID_W-1:0] cand;
  logic            hit;

  // First requester after the pointer wins; the pointer itself is searched last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    hit     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (!hit && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        hit           = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one start/ready fp adder between N_REQ
// requesters. One operation is in flight at a time; operands are held in
// local registers from issue until the response so the adder can sample
// them late. Results (or timeout errors) return tagged with the requester id.
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [FP32_W*N_REQ-1:0] req_a,
  input  logic [FP32_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fu_start,
  output logic                    fu_op,
  output logic [FP32_W-1:0]       fu_a,
  output logic [FP32_W-1:0]       fu_b,
  input  logic                    fu_ready,
  input  logic [FP32_W-1:0]       fu_c,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP32_W-1:0]       resp_data,
  output logic                    resp_err,
  output logic                    busy
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               op_q, op_d;
  logic [FP32_W-1:0]  a_q, a_d;
  logic [FP32_W-1:0]  b_q, b_d;
  logic [FP32_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_found;
  logic               cnt_last;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  // This cycle is the TIMEOUT-th one spent in the current wait state.
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a returning ready wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fu_ready) state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!fu_ready)     state_d = ST_WAIT_DONE;
        else if (cnt_last) state_d = ST_RESP;
      end
      ST_WAIT_DONE: begin
        if (fu_ready || cnt_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: operands are presented from ISSUE through RESP and never
  // change in between, covering the adder's late operand sampling.
  always_comb begin
    req_ready  = '0;
    fu_start   = 1'b0;
    fu_op      = 1'b0;
    fu_a       = '0;
    fu_b       = '0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    busy       = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (!rst) req_ready = arb_grant;
      end
      ST_ISSUE: begin
        fu_start = fu_ready;
        fu_op    = op_q;
        fu_a     = a_q;
        fu_b     = b_q;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        fu_op = op_q;
        fu_a  = a_q;
        fu_b  = b_q;
      end
      ST_RESP: begin
        fu_op      = op_q;
        fu_a       = a_q;
        fu_b       = b_q;
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_data  = data_q;
        resp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

  // Holding registers, round-robin pointer and wait-state timeout counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          id_d     = arb_idx;
          rr_ptr_d = arb_idx;
          op_d     = req_op[arb_idx];
          a_d      = req_a[int'(arb_idx)*FP32_W +: FP32_W];
          b_d      = req_b[int'(arb_idx)*FP32_W +: FP32_W];
          data_d   = '0;
          err_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (!fu_ready) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            err_d  = 1'b1;
            data_d = '0;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (fu_ready) begin
          data_d = fu_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            err_d  = 1'b1;
            data_d = '0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; the pointer resets so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= ID_W'(N_REQ - 1);
      id_q     <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
